// File: rtl/alu_pkg.sv
// Shared definitions for the multi-cycle ALU:
// op encodings, status flag bit positions and FSM states.
package alu_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_NOTB = 3'b011,
    OP_LSL = 3'b100,
    OP_ASR = 3'b101,
    OP_MUL = 3'b110,
    OP_RSV = 3'b111
  } alu_op_e;

  localparam int Z_ZERO = 0;
  localparam int Z_NEG = 1;
  localparam int Z_OVF = 2;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_BUSY = 2'b01,
    S_DONE = 2'b10
  } state_e;

endpackage

// File: rtl/alu_mul_seq.sv
// Iterative shift-add unsigned multiplier.
// The first partial product is taken on start; done marks the final one.
module alu_mul_seq #(
  parameter int W = 16
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic           done,
  output logic [2*W-1:0] product
);

  localparam int CW = $clog2(W);

  logic [2*W-1:0] mcand;
  logic [W-1:0]   mplier;
  logic [CW-1:0]  cnt;
  logic           run;

  always_ff @(posedge clk) begin
    if (reset) begin
      mcand   <= '0;
      mplier  <= '0;
      product <= '0;
      cnt     <= '0;
      run     <= 1'b0;
    end else if (start) begin
      mcand   <= {{W{1'b0}}, a} << 1;
      mplier  <= b >> 1;
      product <= b[0] ? {{W{1'b0}}, a} : '0;
      cnt     <= CW'(W - 1);
      run     <= 1'b1;
    end else if (run) begin
      if (cnt != '0) begin
        if (mplier[0])
          product <= product + mcand;
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        cnt    <= cnt - 1'b1;
      end else begin
        run <= 1'b0;
      end
    end
  end

  assign done = run && (cnt == '0);

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU: single-cycle ops finish in one cycle,
// MUL runs W cycles on the iterative multiplier.
module alu_mc
  import alu_pkg::*;
#(
  parameter int W = 16,
  parameter int MUL_EN = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] Ain,
  input  logic [W-1:0] Bin,
  input  logic [2:0]   ALUop,
  output logic         out_valid,
  output logic [W-1:0] out,
  output logic [2:0]   Z
);

  state_e state, state_d;

  logic           accept;
  logic           is_mul;
  logic           mul_done;
  logic [2*W-1:0] prod;
  logic [W-1:0]   res;
  logic           ovf;

  assign in_ready  = (state == S_IDLE);
  assign out_valid = (state == S_DONE);
  assign accept    = in_valid & in_ready;
  assign is_mul    = (MUL_EN != 0) && (ALUop == OP_MUL);

  function automatic logic [2:0] flags(
    input logic [W-1:0] r,
    input logic         v
  );
    flags         = '0;
    flags[Z_ZERO] = (r == '0);
    flags[Z_NEG]  = r[W-1];
    flags[Z_OVF]  = v;
  endfunction

  always_comb begin
    res = Ain;
    ovf = 1'b0;
    case (ALUop)
      OP_ADD: begin
        res = Ain + Bin;
        ovf = (Ain[W-1] == Bin[W-1]) &&
              (res[W-1] != Ain[W-1]);
      end
      OP_SUB: begin
        res = Ain - Bin;
        ovf = (Ain[W-1] != Bin[W-1]) &&
              (res[W-1] != Ain[W-1]);
      end
      OP_AND:  res = Ain & Bin;
      OP_NOTB: res = ~Bin;
      OP_LSL:  res = {Ain[W-2:0], 1'b0};
      OP_ASR:  res = {Ain[W-1], Ain[W-1:1]};
      default: res = Ain;
    endcase
  end

  always_comb begin
    state_d = state;
    case (state)
      S_IDLE:
        if (accept)
          state_d = is_mul ? S_BUSY : S_DONE;
      S_BUSY:
        if (mul_done)
          state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset)
      state <= S_IDLE;
    else
      state <= state_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out <= '0;
      Z   <= '0;
    end else if (accept && !is_mul) begin
      out <= res;
      Z   <= flags(res, 1'b0) | (ovf ? 3'b100 : 3'b000);
    end else if (state == S_BUSY && mul_done) begin
      out <= prod[W-1:0];
      Z   <= flags(prod[W-1:0], |prod[2*W-1:W]);
    end
  end

  generate
    if (MUL_EN != 0) begin : g_mul
      alu_mul_seq #(.W(W)) u_mul (
        .clk     (clk),
        .reset   (reset),
        .start   (accept & is_mul),
        .a       (Ain),
        .b       (Bin),
        .done    (mul_done),
        .product (prod)
      );
    end else begin : g_no_mul
      assign mul_done = 1'b0;
      assign prod     = '0;
    end
  endgenerate

endmodule

// File: tb/tb_alu_mc.sv
// Directed bench for alu_mc: vector table on a W=16 instance,
// plus reset/ignore sequences and W=8 / MUL_EN=0 instances.
module tb_alu_mc;
  import alu_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;

  logic v0, r0, ov0;
  logic [15:0] a0, b0, o0;
  logic [2:0] op0, z0;

  logic v1, r1, ov1;
  logic [7:0] a1, b1, o1;
  logic [2:0] op1, z1;

  logic v2, r2, ov2;
  logic [15:0] a2, b2, o2;
  logic [2:0] op2, z2;

  alu_mc #(.W(16), .MUL_EN(1)) dut0 (
    .clk(clk), .reset(reset), .in_valid(v0), .in_ready(r0),
    .Ain(a0), .Bin(b0), .ALUop(op0), .out_valid(ov0),
    .out(o0), .Z(z0)
  );

  alu_mc #(.W(8), .MUL_EN(1)) dut1 (
    .clk(clk), .reset(reset), .in_valid(v1), .in_ready(r1),
    .Ain(a1), .Bin(b1), .ALUop(op1), .out_valid(ov1),
    .out(o1), .Z(z1)
  );

  alu_mc #(.W(16), .MUL_EN(0)) dut2 (
    .clk(clk), .reset(reset), .in_valid(v2), .in_ready(r2),
    .Ain(a2), .Bin(b2), .ALUop(op2), .out_valid(ov2),
    .out(o2), .Z(z2)
  );

  int total = 0;
  int bad = 0;

  task automatic check(input string name,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  function automatic logic rdy(input int i);
    case (i)
      0: return r0;
      1: return r1;
      default: return r2;
    endcase
  endfunction

  function automatic logic vld(input int i);
    case (i)
      0: return ov0;
      1: return ov1;
      default: return ov2;
    endcase
  endfunction

  function automatic logic [15:0] res(input int i);
    case (i)
      0: return o0;
      1: return {8'h00, o1};
      default: return o2;
    endcase
  endfunction

  function automatic logic [2:0] zf(input int i);
    case (i)
      0: return z0;
      1: return z1;
      default: return z2;
    endcase
  endfunction

  task automatic drive(input int i, input logic v,
                       input logic [2:0] op,
                       input logic [15:0] a,
                       input logic [15:0] b);
    case (i)
      0: begin v0 = v; op0 = op; a0 = a; b0 = b; end
      1: begin v1 = v; op1 = op; a1 = a[7:0]; b1 = b[7:0]; end
      default: begin v2 = v; op2 = op; a2 = a; b2 = b; end
    endcase
  endtask

  // One handshake; latency counts cycles from accept to out_valid.
  task automatic do_op(input int i, input logic [2:0] op,
                       input logic [15:0] a, input logic [15:0] b,
                       output logic [15:0] got_o,
                       output logic [2:0] got_z,
                       output int lat, output bit rdy_low);
    int n;
    n = 0;
    @(negedge clk);
    while (!rdy(i) && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("ready_wait", 32'(n < 50), 1);
    drive(i, 1'b1, op, a, b);
    @(posedge clk);
    #1;
    drive(i, 1'b0, 3'(op + 3'd1), ~a, 16'h5A5A);
    lat = 1;
    rdy_low = 1'b1;
    while (!vld(i) && lat < 40) begin
      if (rdy(i)) rdy_low = 1'b0;
      @(posedge clk);
      #1;
      lat++;
    end
    if (rdy(i)) rdy_low = 1'b0;
    got_o = res(i);
    got_z = zf(i);
    @(posedge clk);
    #1;
    check("pulse_len", 32'(vld(i)), 0);
    check("ready_back", 32'(rdy(i)), 1);
  endtask

  typedef struct {
    logic [2:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] eo;
    logic [2:0]  ez;
    int          lat;
  } vec_t;

  vec_t vt[15];

  initial begin
    logic [15:0] go;
    logic [2:0] gz;
    int lat;
    bit rl;
    int pulses;

    vt[0]  = '{OP_ADD,  16'h7FFF, 16'h7FFF, 16'hFFFE, 3'b110, 1};
    vt[1]  = '{OP_SUB,  16'h0001, 16'h0001, 16'h0000, 3'b001, 1};
    vt[2]  = '{OP_SUB,  16'h8000, 16'h0001, 16'h7FFF, 3'b100, 1};
    vt[3]  = '{OP_MUL,  16'h0100, 16'h0100, 16'h0000, 3'b101, 17};
    vt[4]  = '{OP_MUL,  16'h0003, 16'h0005, 16'h000F, 3'b000, 17};
    vt[5]  = '{OP_ASR,  16'h8000, 16'h0000, 16'hC000, 3'b010, 1};
    vt[6]  = '{OP_LSL,  16'h4000, 16'h0000, 16'h8000, 3'b010, 1};
    vt[7]  = '{OP_NOTB, 16'h1234, 16'hFFFF, 16'h0000, 3'b001, 1};
    vt[8]  = '{OP_AND,  16'hF0F0, 16'h3C3C, 16'h3030, 3'b000, 1};
    vt[9]  = '{OP_ADD,  16'h1234, 16'h1111, 16'h2345, 3'b000, 1};
    vt[10] = '{OP_RSV,  16'h8001, 16'h0F0F, 16'h8001, 3'b010, 1};
    vt[11] = '{OP_ADD,  16'hFFFF, 16'h0001, 16'h0000, 3'b001, 1};
    vt[12] = '{OP_SUB,  16'h7FFF, 16'hFFFF, 16'h8000, 3'b110, 1};
    vt[13] = '{OP_MUL,  16'hFFFF, 16'hFFFF, 16'h0001, 3'b100, 17};
    vt[14] = '{OP_ASR,  16'h7FFE, 16'h0000, 16'h3FFF, 3'b000, 1};

    reset = 1'b1;
    drive(0, 1'b0, OP_ADD, 16'h0, 16'h0);
    drive(1, 1'b0, OP_ADD, 16'h0, 16'h0);
    drive(2, 1'b0, OP_ADD, 16'h0, 16'h0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    check("rst_ready0", 32'(r0), 1);
    check("rst_valid0", 32'(ov0), 0);
    check("rst_out0", 32'(o0), 0);
    check("rst_z0", 32'(z0), 0);
    check("rst_ready1", 32'(r1), 1);
    check("rst_ready2", 32'(r2), 1);

    for (int k = 0; k < 15; k++) begin
      do_op(0, vt[k].op, vt[k].a, vt[k].b, go, gz, lat, rl);
      check($sformatf("v%0d_out", k), 32'(go), 32'(vt[k].eo));
      check($sformatf("v%0d_z", k), 32'(gz), 32'(vt[k].ez));
      check($sformatf("v%0d_lat", k), lat, vt[k].lat);
      if (vt[k].op == OP_MUL)
        check($sformatf("v%0d_rdy_low", k), 32'(rl), 1);
    end

    // Reset in the 5th BUSY cycle of a MUL
    @(negedge clk);
    drive(0, 1'b1, OP_MUL, 16'h0003, 16'h0005);
    @(posedge clk);
    #1 drive(0, 1'b0, OP_ADD, 16'h0, 16'h0);
    repeat (4) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    check("abort_out", 32'(o0), 0);
    check("abort_z", 32'(z0), 0);
    check("abort_valid", 32'(ov0), 0);
    check("abort_ready", 32'(r0), 1);
    pulses = 0;
    repeat (25) begin
      @(posedge clk);
      #1 if (ov0) pulses++;
    end
    check("abort_pulses", pulses, 0);

    // in_valid toggled while busy is ignored
    @(negedge clk);
    drive(0, 1'b1, OP_MUL, 16'h0003, 16'h0005);
    @(posedge clk);
    pulses = 0;
    for (int c = 0; c < 30; c++) begin
      #1;
      if (ov0) pulses++;
      if (c < 10)
        drive(0, c[0], OP_ADD, 16'h0001, 16'h0001);
      else
        drive(0, 1'b0, OP_ADD, 16'h0001, 16'h0001);
      @(posedge clk);
    end
    #1;
    check("busy_pulses", pulses, 1);
    check("busy_out", 32'(o0), 32'h000F);

    do_op(1, OP_ADD, 16'h0080, 16'h0080, go, gz, lat, rl);
    check("w8_add_out", 32'(go), 32'h00);
    check("w8_add_z", 32'(gz), 32'b101);
    check("w8_add_lat", lat, 1);
    do_op(1, OP_MUL, 16'h0010, 16'h0010, go, gz, lat, rl);
    check("w8_mul_out", 32'(go), 32'h00);
    check("w8_mul_z", 32'(gz), 32'b101);
    check("w8_mul_lat", lat, 9);
    do_op(1, OP_SUB, 16'h0080, 16'h0001, go, gz, lat, rl);
    check("w8_sub_out", 32'(go), 32'h7F);
    check("w8_sub_z", 32'(gz), 32'b100);

    do_op(2, OP_MUL, 16'h1234, 16'h0002, go, gz, lat, rl);
    check("nomul_out", 32'(go), 32'h1234);
    check("nomul_z", 32'(gz), 32'b000);
    check("nomul_lat", lat, 1);
    do_op(2, OP_RSV, 16'h8000, 16'h0002, go, gz, lat, rl);
    check("nomul_rsv_out", 32'(go), 32'h8000);
    check("nomul_rsv_z", 32'(gz), 32'b010);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_mc.md
ALU_MC -- requirements
Module: alu_mc

Interface
REQ-001 Parameter W, default 16, datapath width in bits (W >= 4).
REQ-002 Parameter MUL_EN, default 1, enables the iterative multiply op (0 = op 110 treated as reserved).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  operation request.
REQ-006 in_ready  output  1  block can accept an operation.
REQ-007 Ain  input  W  operand A.
REQ-008 Bin  input  W  operand B.
REQ-009 ALUop  input  3  operation select.
REQ-010 out_valid  output  1  one-cycle pulse marking a new result.
REQ-011 out  output  W  registered result.
REQ-012 Z  output  3  registered status: Z[0] zero, Z[1] negative, Z[2] overflow.

Function
REQ-013 Ops SHALL be: 000 ADD, 001 SUB (A-B), 010 AND, 011 NOT B, 100 LSL A by 1, 101 ASR A by 1, 110 MUL (low W bits of unsigned A*B), 111 reserved (out = Ain).
REQ-014 FSM SHALL have states IDLE, BUSY, DONE; in_ready = 1 only in IDLE.
REQ-015 Accept occurs on a rising edge with in_valid & in_ready; Ain, Bin, ALUop SHALL be captured then and later input changes ignored.
REQ-016 Non-MUL op: IDLE -> DONE on accept; out, Z, out_valid=1 visible the cycle after accept (latency 1).
REQ-017 MUL op: IDLE -> BUSY on accept; one shift-add step per cycle for W cycles; BUSY -> DONE; out_valid asserted W+1 cycles after accept.
REQ-018 DONE SHALL last exactly one cycle then return to IDLE; out_valid high only in DONE.
REQ-019 out and Z SHALL hold their last values until the next DONE.
REQ-020 Z[0] = (out == 0); Z[1] = out[W-1], for every op.
REQ-021 Z[2] = signed two's-complement overflow for ADD and SUB; for MUL, Z[2] = 1 when the upper W bits of the 2W-bit unsigned product are nonzero; 0 for all other ops.
REQ-022 ADD/SUB results SHALL wrap modulo 2^W.
REQ-023 in_valid asserted while in BUSY or DONE SHALL be ignored (no queuing).
REQ-024 With MUL_EN = 0, op 110 SHALL behave as op 111 with latency 1.

Reset
REQ-025 While reset is high at a clock edge: state = IDLE, out = 0, Z = 000, out_valid = 0, multiplier state cleared.
REQ-026 in_ready SHALL be 1 in the first cycle after reset deasserts.
REQ-027 Reset during BUSY SHALL abort the operation with no out_valid pulse; reset dominates a simultaneous accept.

Structure
REQ-028 Shared package alu_pkg SHALL hold op encodings, Z bit indices, and FSM state encoding.
REQ-029 Iterative multiplier SHALL be the sub-module alu_mul_seq (start, done, W-bit operands, 2W-bit product), instantiated only when MUL_EN = 1.
REQ-030 Combinational op logic, flag generation and FSM SHALL reside in alu_mc.

Verification (W = 16 unless stated)
REQ-031 ADD 0x7FFF + 0x7FFF -> out 0xFFFE, Z = 110, out_valid exactly 1 cycle after accept.
REQ-032 SUB 0x0001 - 0x0001 -> out 0x0000, Z = 001; SUB 0x8000 - 0x0001 -> out 0x7FFF, Z = 100.
REQ-033 MUL 0x0100 * 0x0100 -> out 0x0000, Z = 101, out_valid exactly 17 cycles after accept, in_ready low throughout; MUL 0x0003 * 0x0005 -> 0x000F, Z = 000.
REQ-034 ASR 0x8000 -> 0xC000, Z = 010; LSL 0x4000 -> 0x8000, Z = 010; NOT B 0xFFFF -> 0x0000, Z = 001.
REQ-035 Reset at 5th BUSY cycle of a MUL -> no out_valid, out = 0, Z = 000, in_ready = 1 after reset drops; in_valid toggled during BUSY -> no extra results.
REQ-036 W = 8 instance: ADD 0x80 + 0x80 -> out 0x00, Z = 101; MUL_EN = 0 instance: op 110 with Ain 0x1234 -> out 0x1234, latency 1.
